// File: rtl/vram_icon_fetch.sv
// VRAM read-port owner: passes the LCD scanner address through, and on each vsync rising
// edge fetches ICON_WORDS nibbles into a sprite enable vector. Optional macro: ICON_STABLE_FILTER_EN.
module vram_icon_fetch #(
    parameter int          ICON_WORDS  = 2,
    parameter logic [63:0] ICON_ADDRS  = 64'h0000_0000_0000_8910,
    parameter int          RAM_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    vsync,
    input  logic [7:0]              lcd_video_addr,
    input  logic [3:0]              video_data,
    output logic [7:0]              video_addr,
    output logic                    fetch_busy,
    output logic [4*ICON_WORDS-1:0] sprite_enable_status,
    output logic                    status_valid
);

    localparam int IDX_W = (ICON_WORDS > 1) ? $clog2(ICON_WORDS) : 1;
    localparam int CNT_W = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY + 1) : 1;
    localparam int SW    = 4 * ICON_WORDS;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ICON_WORDS - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RAM_LATENCY);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [SW-1:0]    SW_ZERO  = {SW{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t           state_r;
    logic             vsync_d_r;
    logic [IDX_W-1:0] idx_r;
    logic [CNT_W-1:0] cnt_r;
    logic [SW-1:0]    shadow_r;
`ifdef ICON_STABLE_FILTER_EN
    logic [SW-1:0]    last_fetch_r;
`endif

    logic             start_s;
    logic             commit_en_s;
    logic [5:0]       icon_sel_s;
    logic [SW-1:0]    shadow_next_s;

    assign start_s = vsync & ~vsync_d_r;

    // Port mux: scanner address unless the fetcher owns the port
    always_comb begin
        icon_sel_s = {3'(idx_r), 3'b000};
        if (fetch_busy) begin
            video_addr = ICON_ADDRS[icon_sel_s +: 8];
        end else begin
            video_addr = lcd_video_addr;
        end
    end

    // Shadow with the current word's nibble replaced by the incoming VRAM data
    always_comb begin
        shadow_next_s = shadow_r;
        for (int i = 0; i < ICON_WORDS; i++) begin
            if (idx_r == IDX_W'(i)) begin
                shadow_next_s[4*i +: 4] = video_data;
            end else begin
                shadow_next_s[4*i +: 4] = shadow_r[4*i +: 4];
            end
        end
    end

    // Commit qualifier: with the filter only two identical consecutive passes publish
    always_comb begin
`ifdef ICON_STABLE_FILTER_EN
        commit_en_s = (shadow_next_s == last_fetch_r);
`else
        commit_en_s = 1'b1;
`endif
    end

    // Fetch sequencer; the commit is registered on the last capture edge so the new
    // status and its valid pulse are visible during the COMMIT cycle itself
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r              <= ST_IDLE;
            vsync_d_r            <= 1'b0;
            idx_r                <= IDX_ZERO;
            cnt_r                <= CNT_ZERO;
            shadow_r             <= SW_ZERO;
            fetch_busy           <= 1'b0;
            sprite_enable_status <= SW_ZERO;
            status_valid         <= 1'b0;
`ifdef ICON_STABLE_FILTER_EN
            last_fetch_r         <= SW_ZERO;
`endif
        end else begin
            vsync_d_r    <= vsync;
            status_valid <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        state_r    <= ST_FETCH;
                        idx_r      <= IDX_ZERO;
                        cnt_r      <= CNT_ZERO;
                        shadow_r   <= SW_ZERO;
                        fetch_busy <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    if (start_s) begin
                        // Abort the pass in progress; nothing from it is published
                        idx_r      <= IDX_ZERO;
                        cnt_r      <= CNT_ZERO;
                        shadow_r   <= SW_ZERO;
                        fetch_busy <= 1'b1;
                    end else if (cnt_r == LAST_CNT) begin
                        shadow_r <= shadow_next_s;
                        cnt_r    <= CNT_ZERO;
                        if (idx_r == LAST_IDX) begin
                            state_r    <= ST_COMMIT;
                            idx_r      <= IDX_ZERO;
                            fetch_busy <= 1'b0;
`ifdef ICON_STABLE_FILTER_EN
                            last_fetch_r <= shadow_next_s;
`endif
                            if (commit_en_s) begin
                                sprite_enable_status <= shadow_next_s;
                                status_valid         <= 1'b1;
                            end else begin
                                status_valid <= 1'b0;
                            end
                        end else begin
                            idx_r <= idx_r + IDX_ONE;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_COMMIT: begin
                    if (start_s) begin
                        state_r    <= ST_FETCH;
                        idx_r      <= IDX_ZERO;
                        cnt_r      <= CNT_ZERO;
                        shadow_r   <= SW_ZERO;
                        fetch_busy <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    idx_r      <= IDX_ZERO;
                    cnt_r      <= CNT_ZERO;
                    fetch_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vram_icon_fetch.sv
// Bench for vram_icon_fetch: two configurations driven with shared stimulus, each compared
// every cycle against a pass-counting behavioural model, plus hand-computed literal checks.
module tb_vram_icon_fetch;

`ifdef ICON_STABLE_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        vsync;
    logic [7:0]  lcd_video_addr;
    logic [3:0]  mem [2][256];

    logic [7:0]  va   [2];
    logic        busy [2];
    logic [31:0] stat [2];
    logic        sv   [2];

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [7:0] icon_addr(input logic [63:0] tbl, input int w);
        return tbl[8*w +: 8];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int          W = (g == 0) ? 2 : 4;
        localparam int          L = (g == 0) ? 1 : 2;
        localparam logic [63:0] A = (g == 0) ? 64'h0000_0000_0000_8910 : 64'h0000_0000_4030_2010;
        localparam int          P = W * (L + 1);

        logic [7:0]     va_s;
        logic           busy_s;
        logic [4*W-1:0] st_s;
        logic           sv_s;
        logic [3:0]     vd_s;
        logic [7:0]     apipe [3];

        vram_icon_fetch #(.ICON_WORDS(W), .ICON_ADDRS(A), .RAM_LATENCY(L)) dut (
            .clk                 (clk),
            .reset               (reset),
            .vsync               (vsync),
            .lcd_video_addr      (lcd_video_addr),
            .video_data          (vd_s),
            .video_addr          (va_s),
            .fetch_busy          (busy_s),
            .sprite_enable_status(st_s),
            .status_valid        (sv_s)
        );

        // VRAM: data for an address appears L cycles after it is presented
        always @(posedge clk) begin
            apipe[0] <= va_s;
            apipe[1] <= apipe[0];
            apipe[2] <= apipe[1];
        end
        assign vd_s = mem[g][apipe[L-1]];

        assign va[g]   = va_s;
        assign busy[g] = busy_s;
        assign stat[g] = 32'(st_s);
        assign sv[g]   = sv_s;

        // Model: m_b counts busy cycles since the start edge (0 = port free)
        int             m_b = 0;
        bit             m_prev = 1'b0;
        bit             m_valid = 1'b0;
        bit             start;
        int             w;
        logic [4*W-1:0] m_shadow = '0;
        logic [4*W-1:0] m_status = '0;
        logic [4*W-1:0] m_last = '0;

        always @(posedge clk) begin
            if (reset) begin
                m_b = 0; m_prev = 1'b0; m_valid = 1'b0;
                m_shadow = '0; m_status = '0; m_last = '0;
            end else begin
                start   = vsync && !m_prev;
                m_prev  = vsync;
                m_valid = 1'b0;
                if (start) begin
                    m_b = 1;
                end else if (m_b > 0) begin
                    if (m_b % (L + 1) == 0) begin
                        w = m_b / (L + 1) - 1;
                        m_shadow[4*w +: 4] = mem[g][icon_addr(A, w)];
                    end
                    if (m_b == P) begin
                        if (FILT) begin
                            if (m_shadow == m_last) begin
                                m_status = m_shadow;
                                m_valid  = 1'b1;
                            end
                            m_last = m_shadow;
                        end else begin
                            m_status = m_shadow;
                            m_valid  = 1'b1;
                        end
                        m_b = 0;
                    end else begin
                        m_b++;
                    end
                end
            end
        end

        always @(negedge clk) begin
            if (check_en) begin
                chk($sformatf("u%0d fetch_busy", g), 32'(busy_s), 32'(m_b > 0));
                chk($sformatf("u%0d video_addr", g), 32'(va_s),
                    32'((m_b > 0) ? icon_addr(A, (m_b - 1) / (L + 1)) : lcd_video_addr));
                chk($sformatf("u%0d status", g), 32'(st_s), 32'(m_status));
                chk($sformatf("u%0d status_valid", g), 32'(sv_s), 32'(m_valid));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame(output int pulses, output logic [31:0] st);
        tick();
        vsync  = 1'b1;
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            pulses += int'(sv[0]);
            tick();
            if (c == 0) vsync = 1'b0;
        end
        st = stat[0];
    endtask

    int          pulses;
    int          busyc;
    logic [31:0] st;
    logic [7:0]  pick;

    initial begin
        reset = 1'b1;
        vsync = 1'b0;
        lcd_video_addr = 8'h00;
        for (int a = 0; a < 256; a++) begin
            mem[0][a] = 4'($urandom);
            mem[1][a] = 4'(a >> 4);
        end
        mem[0][8'h10] = 4'hA;
        mem[0][8'h89] = 4'h5;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_en = 1'b1;
        @(negedge clk);
        chk("reset status", stat[0], 32'h0);
        chk("reset busy", 32'(busy[0]), 32'h0);
        chk("reset valid", 32'(sv[0]), 32'h0);
        chk("reset addr", 32'(va[0]), 32'h0);

        // Single default fetch; second unit uses 4 words with latency 2
        tick();
        vsync = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (c == 1 || c == 2) chk("t1 addr w0", 32'(va[0]), 32'h10);
            if (c == 3 || c == 4) chk("t1 addr w1", 32'(va[0]), 32'h89);
            chk("t1 valid", 32'(sv[0]), 32'((c == 5) && !FILT));
            if (c == 5) chk("t1 status", stat[0], FILT ? 32'h0 : 32'h5A);
            chk("t1 u1 busy", 32'(busy[1]), 32'(c >= 1 && c <= 12));
            if (c == 13) chk("t1 u1 status", stat[1], FILT ? 32'h0 : 32'h4321);
            if (c == 13) chk("t1 u1 valid", 32'(sv[1]), 32'(!FILT));
            tick();
            if (c == 0) vsync = 1'b0;
        end

        // Pass-through sweep while idle
        for (int i = 0; i < 256; i++) begin
            tick();
            lcd_video_addr = 8'(i);
            @(negedge clk);
            if (i % 37 == 0) chk("t2 sweep", 32'(va[0]), 32'(i));
        end
        chk("t2 status held", stat[0], FILT ? 32'h0 : 32'h5A);

        // Restart by a second edge in cycle 3
        tick();
        vsync = 1'b1;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            if (c == 4) chk("t3 restart addr", 32'(va[0]), 32'h10);
            chk("t3 valid", 32'(sv[0]), 32'(c == 8));
            tick();
            if (c == 0 || c == 3) vsync = 1'b0;
            if (c == 2) vsync = 1'b1;
        end
        repeat (20) tick();

        // Start coincident with the commit cycle
        tick();
        vsync = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk("t4 valid", 32'(sv[0]), 32'(c == 5 || c == 10));
            if (c == 6) chk("t4 busy", 32'(busy[0]), 32'h1);
            if (c == 6) chk("t4 addr", 32'(va[0]), 32'h10);
            tick();
            if (c == 0 || c == 5) vsync = 1'b0;
            if (c == 4) vsync = 1'b1;
        end
        repeat (20) tick();

        // Reset in cycle 2 of a fetch, then one edge with a long level-high vsync
        tick();
        vsync = 1'b1;
        lcd_video_addr = 8'h77;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 3) begin
                chk("t5 status", stat[0], 32'h0);
                chk("t5 busy", 32'(busy[0]), 32'h0);
                chk("t5 addr", 32'(va[0]), 32'h77);
                chk("t5 u1 status", stat[1], 32'h0);
            end
            tick();
            if (c == 0) vsync = 1'b0;
            if (c == 1) reset = 1'b1;
            if (c == 2) reset = 1'b0;
        end
        vsync = 1'b1;
        pulses = 0;
        busyc = 0;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            pulses += int'(sv[0]);
            busyc += int'(busy[0]);
            tick();
        end
        vsync = 1'b0;
        chk("t5 level pulses", 32'(pulses), FILT ? 32'h0 : 32'h1);
        chk("t5 level busy", 32'(busyc), 32'h4);
        repeat (20) tick();

`ifdef ICON_STABLE_FILTER_EN
        reset = 1'b1;
        tick();
        reset = 1'b0;
        frame(pulses, st);
        chk("f1 pulses", 32'(pulses), 32'h0);
        chk("f1 status", st, 32'h0);
        frame(pulses, st);
        chk("f2 pulses", 32'(pulses), 32'h1);
        chk("f2 status", st, 32'h5A);
        mem[0][8'h10] = 4'h3;
        mem[0][8'h89] = 4'h3;
        frame(pulses, st);
        chk("f3 pulses", 32'(pulses), 32'h0);
        chk("f3 status", st, 32'h5A);
        repeat (20) tick();
`endif

        // Randomized traffic: edges, restarts, resets and VRAM changes
        for (int n = 0; n < 4000; n++) begin
            tick();
            lcd_video_addr = 8'($urandom);
            if ($urandom_range(0, 9) == 0) vsync = ~vsync;
            reset = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 59) == 0) begin
                case ($urandom_range(0, 4))
                    0: pick = 8'h10;
                    1: pick = 8'h89;
                    2: pick = 8'h20;
                    3: pick = 8'h30;
                    default: pick = 8'h40;
                endcase
                mem[$urandom_range(0, 1)][pick] = 4'($urandom_range(0, 3));
            end
        end
        vsync = 1'b0;
        reset = 1'b0;
        repeat (20) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
